fir_cfg_loader: RTL and testbench
=================================

// Module: fir_cfg_loader
// PURPOSE
// - Sequencer that loads the FIR coefficient/tap shift chain from a host byte stream.
// - Accepts NUM_WORDS bytes over a valid/ready handshake, then drives config_enable,
//   config_data_enable and cfg_data into the coefficient register chain.
// - Asserts filt_hold while the coefficient set is inconsistent (load in progress).
// - Sits between the host/bus interface and the coefficient register block in the FIR top.
// PARAMETERS
// - WORD_W    8    width of one config word (coefficient byte)
// - NUM_WORDS 17   words per frame: tap word first, then h_15 .. h_0
// - TIMEOUT   255  max stall cycles between accepted words (only with CFG_TIMEOUT_EN)
// PORTS
// - clk                 in   1       clock, all logic on rising edge
// - rst                 in   1       synchronous reset, active-high
// - cfg_start           in   1       1-cycle pulse: begin a load frame
// - cfg_abort           in   1       level: abandon the current frame
// - s_data              in   WORD_W  host config word
// - s_valid             in   1       s_data valid
// - s_ready             out  1       loader accepts s_data this cycle
// - cfg_data            out  WORD_W  word to coefficient chain data_in
// - config_enable       out  1       chain configuration window
// - config_data_enable  out  1       1-cycle shift strobe, aligned with cfg_data
// - filt_hold           out  1       freeze filter output while high
// - busy                out  1       frame in progress
// - done                out  1       1-cycle pulse: full frame shifted in
// - err                 out  1       sticky: abort or timeout; cleared by next cfg_start
// BEHAVIOUR
// - Reset: state=IDLE, count=0; s_ready, config_enable, config_data_enable,
//   filt_hold, busy, done, err = 0; cfg_data = 0.
// - All outputs registered except s_ready, which is decoded from state (s_ready = state==LOAD).
// - FSM states: IDLE, ARM, LOAD, DRAIN, DONE.
// - IDLE:  cfg_start=1 -> ARM; err<=0 and count<=0 on the same edge.
//   cfg_start in any other state is ignored.
// - ARM (1 cycle): config_enable=1, filt_hold=1, busy=1 -> LOAD.
//   Guarantees one cycle of enable setup before the first strobe.
// - LOAD: s_ready=1. On s_valid&&s_ready: cfg_data<=s_data, config_data_enable<=1
//   on the next cycle (1-cycle latency, exactly one strobe per accepted word), count++.
//   On acceptance with count==NUM_WORDS-1 -> DRAIN. No word is accepted outside LOAD.
// - DRAIN (1 cycle): the last strobe is visible, config_enable still 1 -> DONE.
// - DONE (1 cycle): done=1, config_enable<=0, filt_hold<=0, busy<=0 on the exit edge -> IDLE.
// - config_enable stays 1 from ARM through DONE.
//   config_data_enable is never 1 while config_enable is 0.
// - Word order: the first accepted word ends in the tap register (low 4 bits used).
//   The last accepted word ends in h_0.
// - count width = $clog2(NUM_WORDS+1). count saturates; it never wraps within a frame.
// - cfg_abort=1 in ARM/LOAD/DRAIN: next state IDLE, err<=1.
//   config_enable, config_data_enable, filt_hold and busy all go 0 on that edge.
//   No done pulse. A strobe already registered is dropped.
//   Words already shifted remain in the chain; the host must reload.
// - cfg_abort in the same cycle as an accepting handshake: abort wins.
//   The word is consumed (s_ready was 1), no strobe is issued.
// - cfg_abort in IDLE or DONE: no effect.
// - rst mid-frame: immediate return to reset values. The chain keeps its own reset behaviour.
// CONFIGURATION
// - CFG_TIMEOUT_EN defined: stall counter (width $clog2(TIMEOUT+1)).
//   - Clears on every accepted word and on entry to LOAD; increments each LOAD cycle without a handshake.
//   - Reaching TIMEOUT acts exactly as cfg_abort (err<=1, -> IDLE).
// - CFG_TIMEOUT_EN undefined: no stall counter. LOAD waits indefinitely; err is set only by cfg_abort.
// TESTING
// - Reset, then idle 10 cycles -> all outputs 0, s_ready=0.
// - cfg_start, then 17 back-to-back words 0x05,0x10..0x1F -> 17 strobes on consecutive cycles.
//   Also check: done pulse 3 cycles after the last acceptance, tap=5, h_0=0x1F, h_15=0x10.
// - Same frame with s_valid toggling 1/0 -> 17 strobes total, none in gaps, cfg_data matches each word.
// - cfg_abort after 6 words -> err=1, busy=0, no done.
//   Also check: the next cfg_start clears err and a full frame loads correctly.
// - cfg_start asserted during LOAD and in DONE -> ignored, count unaffected, single done.
// - CFG_TIMEOUT_EN, TIMEOUT=8: stall 8 cycles after word 3 -> err=1, IDLE.
//   Also check: a 7-cycle stall completes normally.

Source files
------------

// File: rtl/fir_cfg_loader.sv
// fir_cfg_loader -- loads the FIR tap/coefficient shift chain from a host byte stream.
//
// Purpose : takes NUM_WORDS words (tap word first, then h_15 .. h_0) over a valid/ready
//           handshake and replays each accepted word into the coefficient chain as a
//           one-cycle shift strobe. While a frame is in flight the coefficient set is
//           inconsistent, so filt_hold freezes the filter output.
// Latency : one cycle from an accepted word to its strobe. The done pulse follows three
//           cycles after the last acceptance (DRAIN, DONE, then the exit edge).
// Backpressure: s_ready is high only in LOAD. Outside LOAD no word is taken.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   cfg_start           one-cycle pulse that starts a frame (honoured only in IDLE)
//   cfg_abort           level that abandons the frame in ARM/LOAD/DRAIN
//   s_data/s_valid      host word and its valid flag; s_ready is the accept flag
//   cfg_data            word presented to the coefficient chain data input
//   config_enable       chain configuration window (ARM through DONE)
//   config_data_enable  shift strobe, aligned with cfg_data
//   filt_hold           filter output freeze
//   busy / done / err   frame in progress / end-of-frame pulse / sticky abort flag
//
// Optional feature: define CFG_TIMEOUT_EN to add a stall watchdog. LOAD then gives up
// after TIMEOUT consecutive cycles without an accepted word.

module fir_cfg_loader #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 17,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] cfg_data,
  output logic              config_enable,
  output logic              config_data_enable,
  output logic              filt_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_word;
  logic             timeout_hit;
  logic             abort_req;

  // The only combinational output: ready follows the state directly.
  assign s_ready   = (state == LOAD);
  assign accept    = s_valid && s_ready;
  assign last_word = (count == CNT_W'(NUM_WORDS - 1));

`ifdef CFG_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;

  // Fires in the TIMEOUT-th consecutive LOAD cycle without a handshake, so the
  // frame is abandoned on that cycle's edge.
  assign timeout_hit = (state == LOAD) && !accept &&
                       (stall_cnt == STALL_W'(TIMEOUT - 1));

  // Held at zero outside LOAD, which also clears it on every entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state != LOAD) || accept) begin
      stall_cnt <= '0;
    end else if (!timeout_hit) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // Abort is only meaningful while a frame is actually in flight; DONE has already
  // committed the full set, so it is left to finish.
  assign abort_req = (cfg_abort && (state inside {ARM, LOAD, DRAIN})) || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      count              <= '0;
      cfg_data           <= '0;
      config_enable      <= 1'b0;
      config_data_enable <= 1'b0;
      filt_hold          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      // Strobe and done are single-cycle pulses unless re-asserted below.
      config_data_enable <= 1'b0;
      done               <= 1'b0;

      if (abort_req) begin
        // Any strobe pending from an accepted word is dropped by the default above;
        // a word handshaked in this same cycle is consumed but never shifted.
        state         <= IDLE;
        err           <= 1'b1;
        config_enable <= 1'b0;
        filt_hold     <= 1'b0;
        busy          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_start) begin
              state         <= ARM;
              err           <= 1'b0;
              count         <= '0;
              config_enable <= 1'b1;
              filt_hold     <= 1'b1;
              busy          <= 1'b1;
            end
          end

          // One cycle of enable setup before the chain sees its first strobe.
          ARM: state <= LOAD;

          LOAD: begin
            if (accept) begin
              cfg_data           <= s_data;
              config_data_enable <= 1'b1;
              if (count != CNT_W'(NUM_WORDS)) begin
                count <= count + 1'b1;
              end
              if (last_word) begin
                state <= DRAIN;
              end
            end
          end

          // The last strobe is on the wire this cycle with the window still open.
          DRAIN: state <= DONE;

          DONE: begin
            state         <= IDLE;
            done          <= 1'b1;
            config_enable <= 1'b0;
            filt_hold     <= 1'b0;
            busy          <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_cfg_loader.sv
// Bench for fir_cfg_loader: randomized frames checked against a transaction-level model
// of the host stream and of the downstream coefficient shift chain.

module tb_fir_cfg_loader;

  localparam int NW         = 17;
  localparam int TB_TIMEOUT = 8;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic       cfg_abort;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] cfg_data;
  logic       config_enable;
  logic       config_data_enable;
  logic       filt_hold;
  logic       busy;
  logic       done;
  logic       err;

  fir_cfg_loader #(
    .WORD_W   (8),
    .NUM_WORDS(NW),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_start         (cfg_start),
    .cfg_abort         (cfg_abort),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .cfg_data          (cfg_data),
    .config_enable     (config_enable),
    .config_data_enable(config_data_enable),
    .filt_hold         (filt_hold),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk;
  int         n_pass;
  bit         mon_on;
  logic [7:0] words[NW];
  logic [7:0] chain_q[$];   // model of the coefficient chain: index 0 = tap, NW-1 = h_0

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream chain: shifts cfg_data in on every strobe, oldest word at the tap end.
  always @(negedge clk) begin
    if (mon_on) begin
      check("stb_without_enable", 32'(config_data_enable && !config_enable), 0);
      if (config_data_enable && config_enable) begin
        chain_q.push_back(cfg_data);
        if (chain_q.size() > NW) void'(chain_q.pop_front());
      end
    end
  end

  task automatic check_aborted(input string tag);
    check({tag, "_err"},   32'(err), 1);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_cen"},   32'(config_enable), 0);
    check({tag, "_hold"},  32'(filt_hold), 0);
    check({tag, "_stb"},   32'(config_data_enable), 0);
    check({tag, "_rdy"},   32'(s_ready), 0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      step();
      check({tag, "_no_done"},    32'(done), 0);
      check({tag, "_err_sticky"}, 32'(err), 1);
      check({tag, "_idle_stb"},   32'(config_data_enable), 0);
    end
    s_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid toggling, 2 random gaps (at most 3 in a row)
  task automatic run_frame(input int abort_at, input int gap_mode, input int stall_after,
                           input int stall_len, input bit poke);
    int         idx;
    int         run;
    int         stalled;
    int         cyc;
    bit         pend;
    bit         v;
    bit         ab;
    logic [7:0] pend_w;

    cfg_start = 1'b1;
    s_valid   = 1'($urandom_range(0, 1));
    s_data    = 8'($urandom);
    step();
    cfg_start = 1'b0;
    check("arm_cen",     32'(config_enable), 1);
    check("arm_hold",    32'(filt_hold), 1);
    check("arm_busy",    32'(busy), 1);
    check("arm_rdy",     32'(s_ready), 0);
    check("arm_err_clr", 32'(err), 0);
    check("arm_stb",     32'(config_data_enable), 0);
    step();

    idx = 0; run = 0; stalled = 0; cyc = 0; pend = 0; pend_w = '0;
    while (idx < NW) begin
      check("ld_rdy",  32'(s_ready), 1);
      check("ld_cen",  32'(config_enable), 1);
      check("ld_busy", 32'(busy), 1);
      check("ld_hold", 32'(filt_hold), 1);
      check("ld_done", 32'(done), 0);
      check("ld_stb",  32'(config_data_enable), 32'(pend));
      if (pend) check("ld_dat", 32'(cfg_data), 32'(pend_w));

      ab = (idx == abort_at);
      if (idx == stall_after && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = (run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
      end
      if (ab) v = 1'b1;   // handshake in the abort cycle: abort must still win
      cfg_abort = ab;
      s_valid   = v;
      s_data    = v ? words[idx] : 8'($urandom);
      cfg_start = poke && (idx == 4);
      step();
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      s_valid   = 1'b0;

      if (ab) begin
        check_aborted("abort");
        return;
      end
      if (v) begin
        pend   = 1'b1;
        pend_w = words[idx];
        idx++;
        run = 0;
      end else begin
        pend = 1'b0;
        run++;
`ifdef CFG_TIMEOUT_EN
        if (run == TB_TIMEOUT) begin
          check_aborted("timeout");
          return;
        end
`endif
      end
      cyc++;
    end

    // DRAIN: last strobe visible, window still open
    check("dr_stb",  32'(config_data_enable), 1);
    check("dr_dat",  32'(cfg_data), 32'(pend_w));
    check("dr_rdy",  32'(s_ready), 0);
    check("dr_cen",  32'(config_enable), 1);
    check("dr_done", 32'(done), 0);
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    step();
    // DONE state
    check("dn_stb",  32'(config_data_enable), 0);
    check("dn_cen",  32'(config_enable), 1);
    check("dn_done", 32'(done), 0);
    check("dn_rdy",  32'(s_ready), 0);
    s_valid   = 1'b0;
    cfg_start = poke;
    step();
    cfg_start = 1'b0;
    // three cycles after the last acceptance
    check("done_pulse", 32'(done), 1);
    check("end_cen",    32'(config_enable), 0);
    check("end_hold",   32'(filt_hold), 0);
    check("end_busy",   32'(busy), 0);
    check("end_err",    32'(err), 0);
    step();
    check("done_width",  32'(done), 0);
    check("idle_busy",   32'(busy), 0);
    check("idle_cen",    32'(config_enable), 0);

    check("chain_len", 32'(chain_q.size()), NW);
    if (chain_q.size() == NW) begin
      check("chain_tap",  32'(chain_q[0][3:0]), 32'(words[0][3:0]));
      check("chain_h15",  32'(chain_q[1]), 32'(words[1]));
      check("chain_h0",   32'(chain_q[NW-1]), 32'(words[NW-1]));
      for (int i = 1; i < NW - 1; i++) check("chain_word", 32'(chain_q[i]), 32'(words[i]));
    end
  endtask

  task automatic fill_directed();
    words[0] = 8'h05;
    for (int i = 1; i < NW; i++) words[i] = 8'(8'h0F + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; mon_on = 1'b0;
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Idle after reset with noise on the host side and abort: nothing may move.
    for (int i = 0; i < 10; i++) begin
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = 8'($urandom);
      cfg_abort = 1'($urandom_range(0, 1));
      step();
      check("idle_outputs",
            32'({s_ready, config_enable, config_data_enable, filt_hold, busy, done, err, cfg_data}), 0);
    end
    cfg_abort = 1'b0;
    s_valid   = 1'b0;

    fill_directed();
    run_frame(-1, 0, -1, 0, 1'b0);       // back-to-back directed frame
    run_frame(-1, 1, -1, 0, 1'b0);       // valid toggling
    fill_random();
    run_frame(6, 2, -1, 0, 1'b0);        // abort after 6 words
    fill_random();
    run_frame(-1, 2, -1, 0, 1'b0);       // reload after abort clears err
    fill_random();
    run_frame(-1, 0, -1, 0, 1'b1);       // cfg_start poked in LOAD and DONE
    fill_random();
    run_frame(-1, 0, 3, TB_TIMEOUT, 1'b0);      // long stall after word 3
    fill_random();
    run_frame(-1, 0, 3, TB_TIMEOUT - 1, 1'b0);  // stall one short of the limit
    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame(-1, 2, -1, 0, 1'b0);
    end

    // Reset in the middle of a frame returns everything to reset values.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    step();
    check("rst_midframe",
          32'({s_ready, config_enable, config_data_enable, filt_hold, busy, done, err, cfg_data}), 0);
    rst = 1'b0;
    step();
    check("rst_after_idle", 32'({s_ready, busy, done, err}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
